// File: rtl/store_buffer_if.sv
// Core/dcache-facing bundle of the store buffer: store issue,
// load forwarding lookup, and the dcache write port.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [29:0] st_addr;
  logic [63:0] st_data;
  logic [7:0]  st_mask;

  logic [29:0] ld_addr;
  logic [63:0] ld_data;
  logic [7:0]  ld_mask;
  logic        ld_hit;

  logic        wr_valid;
  logic        wr_ready;
  logic [29:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;

  modport slave (
    input  st_valid, st_addr, st_data, st_mask,
    input  ld_addr,
    input  wr_ready,
    output st_ready,
    output ld_data, ld_mask, ld_hit,
    output wr_valid, wr_addr, wr_data, wr_mask
  );

  modport master (
    output st_valid, st_addr, st_data, st_mask,
    output ld_addr,
    output wr_ready,
    input  st_ready,
    input  ld_data, ld_mask, ld_hit,
    input  wr_valid, wr_addr, wr_data, wr_mask
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO to the dcache with
// youngest-wins byte forwarding to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  store_buffer_if.slave    sb,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [29:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic enq, deq;

  assign enq = sb.st_valid && sb.st_ready;
  assign deq = sb.wr_valid && sb.wr_ready;

  // st_ready looks only at registered occupancy, never at wr_ready
  assign sb.st_ready = (count_q != CNT_W'(DEPTH));
  assign sb.wr_valid = (count_q != '0);
  assign sb.wr_addr  = mem_q[head_q].addr;
  assign sb.wr_data  = mem_q[head_q].data;
  assign sb.wr_mask  = mem_q[head_q].mask;

  assign count = count_q;
  assign empty = (count_q == '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem_q[tail_q] <= '{addr: sb.st_addr,
                         data: sb.st_data,
                         mask: sb.st_mask};
    end
  end

  logic [PW-1:0] idx;
  logic [63:0]   fwd_data;
  logic [7:0]    fwd_mask;

  // Walk oldest to youngest from head so later matches overwrite
  // earlier ones; the pointer arithmetic handles wrap.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    idx      = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && mem_q[idx].addr == sb.ld_addr) begin
        for (int b = 0; b < 8; b++) begin
          if (mem_q[idx].mask[b]) begin
            fwd_mask[b]        = 1'b1;
            fwd_data[8*b +: 8] = mem_q[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  assign sb.ld_data = fwd_data;
  assign sb.ld_mask = fwd_mask;
  assign sb.ld_hit  = |fwd_mask;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table for forwarding
// merge plus hand sequences for fill, wrap, enq+deq and reset.
module tb_store_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if sbif();
  logic [2:0] count;
  logic       empty;

  store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif.slave),
    .count (count),
    .empty (empty)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [29:0] a,
                       input logic [63:0] d, input logic [7:0] m,
                       input logic [29:0] la, input logic wr);
    sbif.st_valid = v;
    sbif.st_addr  = a;
    sbif.st_data  = d;
    sbif.st_mask  = m;
    sbif.ld_addr  = la;
    sbif.wr_ready = wr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st_valid;
    logic [29:0] st_addr;
    logic [63:0] st_data;
    logic [7:0]  st_mask;
    logic [29:0] ld_addr;
    logic        wr_ready;
    logic        e_st_ready;
    logic        e_wr_valid;
    logic [29:0] e_wr_addr;
    logic [2:0]  e_count;
    logic [7:0]  e_ld_mask;
    logic [63:0] e_ld_data;
  } vec_t;

  localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] DB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] DC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;

  vec_t tbl [10];

  logic [29:0] w_addr [6];
  logic [63:0] w_data [6];
  logic [7:0]  w_mask [6];
  logic [2:0]  w_cnt  [6];

  initial begin
    tbl[0] = '{1'b1, 30'h20, DA, 8'h0F, 30'h20, 1'b0,
               1'b1, 1'b0, 30'h00, 3'd0, 8'h00, 64'h0};
    tbl[1] = '{1'b1, 30'h20, DB, 8'h3C, 30'h20, 1'b0,
               1'b1, 1'b1, 30'h20, 3'd1, 8'h0F,
               64'h0000_0000_AAAA_AAAA};
    tbl[2] = '{1'b1, 30'h21, DC, 8'hFF, 30'h20, 1'b0,
               1'b1, 1'b1, 30'h20, 3'd2, 8'h3F,
               64'h0000_BBBB_BBBB_AAAA};
    tbl[3] = '{1'b0, 30'h00, 64'h0, 8'h00, 30'h20, 1'b0,
               1'b1, 1'b1, 30'h20, 3'd3, 8'h3F,
               64'h0000_BBBB_BBBB_AAAA};
    tbl[4] = '{1'b0, 30'h00, 64'h0, 8'h00, 30'h22, 1'b0,
               1'b1, 1'b1, 30'h20, 3'd3, 8'h00, 64'h0};
    tbl[5] = '{1'b0, 30'h00, 64'h0, 8'h00, 30'h21, 1'b0,
               1'b1, 1'b1, 30'h20, 3'd3, 8'hFF, DC};
    tbl[6] = '{1'b0, 30'h00, 64'h0, 8'h00, 30'h20, 1'b1,
               1'b1, 1'b1, 30'h20, 3'd3, 8'h3F,
               64'h0000_BBBB_BBBB_AAAA};
    tbl[7] = '{1'b0, 30'h00, 64'h0, 8'h00, 30'h20, 1'b1,
               1'b1, 1'b1, 30'h20, 3'd2, 8'h3C,
               64'h0000_BBBB_BBBB_0000};
    tbl[8] = '{1'b0, 30'h00, 64'h0, 8'h00, 30'h20, 1'b1,
               1'b1, 1'b1, 30'h21, 3'd1, 8'h00, 64'h0};
    tbl[9] = '{1'b0, 30'h00, 64'h0, 8'h00, 30'h21, 1'b0,
               1'b1, 1'b0, 30'h00, 3'd0, 8'h00, 64'h0};

    w_addr = '{30'h40, 30'h41, 30'h42, 30'h43, 30'h30, 30'h30};
    w_data = '{64'hD0, 64'hD1, 64'hD2, 64'hD3,
               64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202};
    w_mask = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    w_cnt  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};

    // reset and idle
    reset = 1'b1;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h0, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h10, 1'b0);
    chk("rst_wr_valid", 64'(sbif.wr_valid), 64'd0);
    chk("rst_st_ready", 64'(sbif.st_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ld_hit", 64'(sbif.ld_hit), 64'd0);
    chk("rst_ld_data", sbif.ld_data, 64'd0);

    // single store, stall, drain
    drive(1'b1, 30'h10, D1, 8'hFF, 30'h10, 1'b0);
    tick;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h10, 1'b0);
    chk("s1_wr_valid", 64'(sbif.wr_valid), 64'd1);
    chk("s1_wr_addr", 64'(sbif.wr_addr), 64'h10);
    chk("s1_wr_data", sbif.wr_data, D1);
    chk("s1_wr_mask", 64'(sbif.wr_mask), 64'hFF);
    chk("s1_count", 64'(count), 64'd1);
    chk("s1_ld_data", sbif.ld_data, D1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("s1_stall_valid", 64'(sbif.wr_valid), 64'd1);
      chk("s1_stall_addr", 64'(sbif.wr_addr), 64'h10);
      chk("s1_stall_data", sbif.wr_data, D1);
    end
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h10, 1'b1);
    tick;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h10, 1'b0);
    chk("s1_empty", 64'(empty), 64'd1);
    chk("s1_wr_valid_off", 64'(sbif.wr_valid), 64'd0);

    // fill, reject when full, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 30'(i), 64'(i), 8'hFF, 30'h0, 1'b0);
      tick;
    end
    drive(1'b1, 30'h5, 64'h5, 8'hFF, 30'h0, 1'b1);
    chk("full_st_ready", 64'(sbif.st_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_head", 64'(sbif.wr_addr), 64'd1);
    tick;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h0, 1'b0);
    chk("pulse_count", 64'(count), 64'd3);
    chk("pulse_st_ready", 64'(sbif.st_ready), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h0, 1'b1);
      chk("drain_addr", 64'(sbif.wr_addr), 64'(i));
      chk("drain_data", sbif.wr_data, 64'(i));
      tick;
    end
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h0, 1'b0);
    chk("drain_empty", 64'(empty), 64'd1);

    // forwarding merge table
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].st_valid, tbl[k].st_addr, tbl[k].st_data,
            tbl[k].st_mask, tbl[k].ld_addr, tbl[k].wr_ready);
      chk("tbl_st_ready", 64'(sbif.st_ready), 64'(tbl[k].e_st_ready));
      chk("tbl_wr_valid", 64'(sbif.wr_valid), 64'(tbl[k].e_wr_valid));
      if (tbl[k].e_wr_valid)
        chk("tbl_wr_addr", 64'(sbif.wr_addr), 64'(tbl[k].e_wr_addr));
      chk("tbl_count", 64'(count), 64'(tbl[k].e_count));
      chk("tbl_ld_mask", 64'(sbif.ld_mask), 64'(tbl[k].e_ld_mask));
      chk("tbl_ld_data", sbif.ld_data, tbl[k].e_ld_data);
      chk("tbl_ld_hit", 64'(sbif.ld_hit), 64'(|tbl[k].e_ld_mask));
      tick;
    end

    // simultaneous enqueue and dequeue at count 2
    drive(1'b1, 30'h50, 64'h50, 8'hFF, 30'h0, 1'b0);
    tick;
    drive(1'b1, 30'h51, 64'h51, 8'hFF, 30'h0, 1'b0);
    tick;
    drive(1'b1, 30'h52, 64'h52, 8'hFF, 30'h0, 1'b1);
    chk("ed_count_pre", 64'(count), 64'd2);
    chk("ed_head_pre", 64'(sbif.wr_addr), 64'h50);
    tick;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h0, 1'b1);
    chk("ed_count_post", 64'(count), 64'd2);
    chk("ed_head_1", 64'(sbif.wr_addr), 64'h51);
    tick;
    chk("ed_head_2", 64'(sbif.wr_addr), 64'h52);
    chk("ed_count_2", 64'(count), 64'd1);
    tick;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h0, 1'b0);
    chk("ed_empty", 64'(empty), 64'd1);

    // wrap-around: newest pair straddles the pointer wrap
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, w_addr[k], w_data[k], w_mask[k], 30'h0, k[0]);
      tick;
      chk("wrap_count", 64'(count), 64'(w_cnt[k]));
    end
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h30, 1'b0);
    chk("wrap_ld_mask", 64'(sbif.ld_mask), 64'hFF);
    chk("wrap_ld_data", sbif.ld_data, 64'h0101_0101_0202_0202);
    chk("wrap_head", 64'(sbif.wr_addr), 64'h43);

    // reset while draining
    chk("mid_wr_valid", 64'(sbif.wr_valid), 64'd1);
    reset = 1'b1;
    drive(1'b1, 30'h60, 64'h60, 8'hFF, 30'h30, 1'b0);
    tick;
    reset = 1'b0;
    drive(1'b0, 30'h0, 64'h0, 8'h0, 30'h30, 1'b0);
    chk("mrst_wr_valid", 64'(sbif.wr_valid), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_st_ready", 64'(sbif.st_ready), 64'd1);
    chk("mrst_ld_hit", 64'(sbif.ld_hit), 64'd0);
    chk("mrst_ld_data", sbif.ld_data, 64'd0);
    tick;
    chk("mrst_hold", 64'(sbif.wr_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
